// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: accepts a WIDTH-bit pattern over valid/ready and
// shifts it out MSB-first with a programmable repeat count and inter-repeat gap.
module serial_pattern_gen #(
    parameter int   WIDTH    = 4,
    parameter int   CNT_W    = 8,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic [CNT_W-1:0] in_repeat,
    input  logic [GAP_W-1:0] in_gap,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pattern_q, pattern_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_cfg_q, gap_cfg_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    assign in_ready = (state_q == S_IDLE) && !abort;

    // Outputs are computed for the state being entered, so each registered
    // output describes the cycle that state occupies.
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        rep_d         = rep_q;
        gap_cfg_d     = gap_cfg_q;
        gap_cnt_d     = gap_cnt_q;
        x_d           = IDLE_BIT;
        x_valid_d     = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d       = S_SHIFT;
                    pattern_d     = in_pattern;
                    shift_d       = {in_pattern[WIDTH-2:0], 1'b0};
                    rep_d         = (in_repeat == '0) ? CNT_W'(1) : in_repeat;
                    gap_cfg_d     = in_gap;
                    bit_idx_d     = '0;
                    x_d           = in_pattern[WIDTH-1];
                    x_valid_d     = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_idx_q != LAST_IDX) begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    x_d       = shift_q[WIDTH-1];
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    x_valid_d = 1'b1;
                end else if (rep_q != CNT_W'(1)) begin
                    rep_d = rep_q - CNT_W'(1);
                    if (gap_cfg_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_cfg_q;
                    end else begin
                        bit_idx_d     = '0;
                        x_d           = pattern_q[WIDTH-1];
                        shift_d       = {pattern_q[WIDTH-2:0], 1'b0};
                        x_valid_d     = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d       = S_SHIFT;
                    bit_idx_d     = '0;
                    x_d           = pattern_q[WIDTH-1];
                    shift_d       = {pattern_q[WIDTH-2:0], 1'b0};
                    x_valid_d     = 1'b1;
                    frame_start_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pattern_q     <= '0;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            rep_q         <= '0;
            gap_cfg_q     <= '0;
            gap_cnt_q     <= '0;
            x_q           <= IDLE_BIT;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            rep_q         <= rep_d;
            gap_cfg_q     <= gap_cfg_d;
            gap_cnt_q     <= gap_cnt_d;
            x_q           <= x_d;
            x_valid_q     <= x_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: a queue of expected per-cycle outputs is built
// from each accepted descriptor and compared against the DUT every cycle.
module tb_serial_pattern_gen;
    localparam int   WIDTH = 4;
    localparam int   CNT_W = 8;
    localparam int   GAP_W = 4;
    localparam logic IDLE  = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_pattern = '0;
    logic [CNT_W-1:0] in_repeat = '0;
    logic [GAP_W-1:0] in_gap = '0;
    logic             abort = 1'b0;
    logic             x, x_valid, frame_start, done, busy;

    serial_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pattern(in_pattern), .in_repeat(in_repeat), .in_gap(in_gap), .abort(abort),
        .x(x), .x_valid(x_valid), .frame_start(frame_start), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic xv;
        logic fs;
        logic dn;
        logic bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic exp_t mk(input logic xb, input logic xv, input logic fs,
                                input logic dn, input logic bz);
        exp_t e;
        e.x = xb; e.xv = xv; e.fs = fs; e.dn = dn; e.bz = bz;
        return e;
    endfunction

    // Whole frame expanded straight from the descriptor: reps x (bits, gap), then done.
    task automatic push_frame(input logic [WIDTH-1:0] pat, input int rep, input int gap);
        int n;
        n = (rep == 0) ? 1 : rep;
        for (int r = 0; r < n; r++) begin
            for (int b = 0; b < WIDTH; b++)
                exp_q.push_back(mk(pat[WIDTH-1-b], 1'b1, b == 0, 1'b0, 1'b1));
            if (r < n - 1)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        exp_q.push_back(mk(IDLE, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic check_outputs(input exp_t e);
        check("x", x, e.x);
        check("x_valid", x_valid, e.xv);
        check("frame_start", frame_start, e.fs);
        check("done", done, e.dn);
        check("busy", busy, e.bz);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] pat, input int rep,
                         input int gap, input logic ab);
        exp_t e;
        logic idle_now;
        logic acc;
        in_valid   = v;
        in_pattern = pat;
        in_repeat  = CNT_W'(rep);
        in_gap     = GAP_W'(gap);
        abort      = ab;
        #1;
        e = (exp_q.size() > 0) ? exp_q[0] : mk(IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outputs(e);
        idle_now = (exp_q.size() == 0) || !exp_q[0].bz;
        check("in_ready", in_ready, idle_now && !ab);
        acc = v && idle_now && !ab;
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (ab && !idle_now) exp_q.delete();
        if (acc) push_frame(pat, rep, gap);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 0, 0, 1'b0);
    endtask

    task automatic check_reset_state();
        check("rst_x", x, IDLE);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        // Power-on reset
        #2;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Single repetition, then three back-to-back, then gapped repetitions
        cycle(1'b1, 4'b1010, 1, 0, 1'b0);
        idle_cycles(6);
        cycle(1'b1, 4'b1010, 3, 0, 1'b0);
        idle_cycles(14);
        cycle(1'b1, 4'b1100, 2, 2, 1'b0);
        idle_cycles(12);

        // Abort on the third bit
        cycle(1'b1, 4'b1010, 2, 0, 1'b0);
        cycle(1'b0, '0, 0, 0, 1'b0);
        cycle(1'b0, '0, 0, 0, 1'b0);
        cycle(1'b0, '0, 0, 0, 1'b1);
        idle_cycles(3);

        // Abort while idle only blocks acceptance
        cycle(1'b1, 4'b0110, 1, 0, 1'b1);
        idle_cycles(2);

        // Asynchronous reset in the middle of a gap
        cycle(1'b1, 4'b1100, 2, 5, 1'b0);
        idle_cycles(6);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // in_valid held across two descriptors; repeat=0 means one repetition
        cycle(1'b1, 4'b1001, 1, 0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0111, 0, 3, 1'b0);
        idle_cycles(8);

        // Maximum repeat count transmitted in full
        cycle(1'b1, 4'b1011, (1 << CNT_W) - 1, 0, 1'b0);
        idle_cycles(((1 << CNT_W) - 1) * WIDTH + 3);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic v;
            logic ab;
            v  = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 39) == 0);
            cycle(v, WIDTH'($urandom), $urandom_range(0, 4),
                  ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3), ab);
        end
        idle_cycles(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at %0t: bench did not complete", $time);
        $fatal(1, "timeout");
    end

endmodule
